mac_div: RTL and testbench

//   Iterative restoring unsigned divider; inverse of mac_mul. Splits a 2N-bit

---
 rtl/mac_div_if.sv | 25 ++
 rtl/mac_div.sv | 127 ++++++++++++
 tb/tb_mac_div.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mac_div_if.sv
// Request/response bundle for the iterative unsigned divider.
// The master drives the dividend, divisor and result-ready; the slave answers.
interface mac_div_if #(
  parameter int N = 16
);
  logic [2*N-1:0] i_div_a;
  logic [N-1:0]   i_div_b;
  logic           i_div_valid;
  logic           o_div_ready;
  logic [N-1:0]   o_div_q;
  logic [N-1:0]   o_div_r;
  logic           o_div_err;
  logic           o_div_valid;
  logic           i_div_ready;

  modport master (
    output i_div_a, i_div_b, i_div_valid, i_div_ready,
    input  o_div_ready, o_div_q, o_div_r, o_div_err, o_div_valid
  );

  modport slave (
    input  i_div_a, i_div_b, i_div_valid, i_div_ready,
    output o_div_ready, o_div_q, o_div_r, o_div_err, o_div_valid
  );
endinterface

// File: rtl/mac_div.sv
// Restoring unsigned divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, valid/ready on both sides.
module mac_div #(
  parameter int INPUT_WIDTH = 16
) (
  input logic     i_clk,
  input logic     i_rst_n,
  mac_div_if.slave bus
);
  localparam int N  = INPUT_WIDTH;
  localparam int OUTPUT_WIDTH = INPUT_WIDTH * 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [N:0]  p_q, p_d;
  logic [N-1:0] sh_q, sh_d;
  logic [N-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] r_q, r_d;
  logic        err_q, err_d;
  logic        vld_q, vld_d;

  logic [N-1:0] a_hi, a_lo;
  logic [N:0]   p_sh, p_nx, b_ext;
  logic         ge;
  logic [N-1:0] sh_nx;

  assign a_hi = bus.i_div_a[OUTPUT_WIDTH-1:N];
  assign a_lo = bus.i_div_a[N-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  // sh_q holds the unconsumed dividend bits; quotient bits enter at the LSB
  always_comb begin
    b_ext = {1'b0, b_q};
    p_sh  = {p_q[N-1:0], sh_q[N-1]};
    ge    = (p_sh >= b_ext);
    p_nx  = ge ? (p_sh - b_ext) : p_sh;
    sh_nx = {sh_q[N-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    sh_d    = sh_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_div_valid) begin
          b_d   = bus.i_div_b;
          p_d   = {1'b0, a_hi};
          sh_d  = a_lo;
          cnt_d = '0;
          if (bus.i_div_b == '0 || a_hi >= bus.i_div_b) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = a_lo;
            err_d   = 1'b1;
            vld_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = p_nx;
        sh_d  = sh_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          q_d     = sh_nx;
          r_d     = p_nx[N-1:0];
          err_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      DONE: begin
        if (bus.i_div_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_div_ready = (state_q == IDLE);
  assign bus.o_div_q     = q_q;
  assign bus.o_div_r     = r_q;
  assign bus.o_div_err   = err_q;
  assign bus.o_div_valid = vld_q;
endmodule

// File: tb/tb_mac_div.sv
// Directed checks of mac_div: results, latency, errors,
// backpressure and mid-run reset.
module tb_mac_div;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mac_div_if #(.N(16)) bus ();

  mac_div #(.INPUT_WIDTH(16)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a,
                         input logic [15:0] b, input logic [15:0] eq,
                         input logic [15:0] er, input logic ee,
                         input int lat);
    int k;
    chk({tag, ".rdy"}, 32'(bus.o_div_ready), 32'd1);
    bus.i_div_a     = a;
    bus.i_div_b     = b;
    bus.i_div_valid = 1'b1;
    step();
    bus.i_div_valid = 1'b0;
    k = 1;
    while (!bus.o_div_valid && k < 40) begin
      step();
      k++;
    end
    chk({tag, ".lat"}, 32'(k), 32'(lat));
    chk({tag, ".q"}, 32'(bus.o_div_q), 32'(eq));
    chk({tag, ".r"}, 32'(bus.o_div_r), 32'(er));
    chk({tag, ".err"}, 32'(bus.o_div_err), 32'(ee));
    chk({tag, ".busy"}, 32'(bus.o_div_ready), 32'd0);
    bus.i_div_ready = 1'b1;
    step();
    bus.i_div_ready = 1'b0;
    chk({tag, ".vld0"}, 32'(bus.o_div_valid), 32'd0);
    chk({tag, ".rdy1"}, 32'(bus.o_div_ready), 32'd1);
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_div_a     = '0;
    bus.i_div_b     = '0;
    bus.i_div_valid = 1'b0;
    bus.i_div_ready = 1'b0;
    step();
    step();
    chk("rst.vld", 32'(bus.o_div_valid), 32'd0);
    chk("rst.q", 32'(bus.o_div_q), 32'd0);
    chk("rst.r", 32'(bus.o_div_r), 32'd0);
    chk("rst.err", 32'(bus.o_div_err), 32'd0);
    chk("rst.rdy", 32'(bus.o_div_ready), 32'd1);
    rst_n = 1'b1;
    step();

    run_div("basic", 32'd12345678, 16'd1000, 16'd12345, 16'd678, 1'b0, 17);
    run_div("maxq", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 17);
    run_div("div0", 32'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
    run_div("ovf", 32'h00010000, 16'd1, 16'hFFFF, 16'h0000, 1'b1, 1);
    run_div("hieq", 32'h00070000, 16'd7, 16'hFFFF, 16'h0000, 1'b1, 1);
    run_div("lo1", 32'h0000FFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 17);
    run_div("msb", 32'h7FFFFFFF, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b0, 17);

    // Backpressure: result held while downstream stalls, new request ignored
    bus.i_div_a     = 32'd100;
    bus.i_div_b     = 16'd7;
    bus.i_div_valid = 1'b1;
    step();
    bus.i_div_valid = 1'b0;
    k = 1;
    while (!bus.o_div_valid && k < 40) begin
      step();
      k++;
    end
    chk("bp.lat", 32'(k), 32'd17);
    for (int i = 0; i < 5; i++) begin
      bus.i_div_valid = (i == 2);
      bus.i_div_a     = 32'd999;
      bus.i_div_b     = 16'd0;
      chk("bp.vld", 32'(bus.o_div_valid), 32'd1);
      chk("bp.q", 32'(bus.o_div_q), 32'd14);
      chk("bp.r", 32'(bus.o_div_r), 32'd2);
      chk("bp.err", 32'(bus.o_div_err), 32'd0);
      chk("bp.rdy", 32'(bus.o_div_ready), 32'd0);
      step();
    end
    bus.i_div_valid = 1'b0;
    bus.i_div_ready = 1'b1;
    step();
    bus.i_div_ready = 1'b0;
    chk("bp.vld0", 32'(bus.o_div_valid), 32'd0);
    chk("bp.idle", 32'(bus.o_div_ready), 32'd1);
    step();
    chk("bp.nopend", 32'(bus.o_div_valid), 32'd0);

    // Reset in cycle T+8 of a run discards the work
    bus.i_div_a     = 32'd12345678;
    bus.i_div_b     = 16'd1000;
    bus.i_div_valid = 1'b1;
    step();
    bus.i_div_valid = 1'b0;
    repeat (7) step();
    chk("mid.busy", 32'(bus.o_div_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid.vld", 32'(bus.o_div_valid), 32'd0);
    chk("mid.rdy", 32'(bus.o_div_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    run_div("post", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
